// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and its system-side user.
// The supervisor takes the slave modport; whatever drives lock, enables and requests takes master.
interface pll_lock_supervisor_if #(
    parameter int NUM_CLOCKS = 2,
    parameter int CNT_W      = 8
);
    logic                  pll_locked;
    logic                  force_relock;
    logic [NUM_CLOCKS-1:0] chan_en;
    logic                  clear_count;
    logic                  pll_rst;
    logic [NUM_CLOCKS-1:0] domain_rst;
    logic                  ready;
    logic [CNT_W-1:0]      lock_loss_count;
    logic [2:0]            state;

    modport master (
        output pll_locked, force_relock, chan_en, clear_count,
        input  pll_rst, domain_rst, ready, lock_loss_count, state
    );

    modport slave (
        input  pll_locked, force_relock, chan_en, clear_count,
        output pll_rst, domain_rst, ready, lock_loss_count, state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock on refclk, pulses the PLL reset, and releases per-domain resets
// in a staggered order once lock has been stable; counts lock losses after release.
module pll_lock_supervisor #(
    parameter int NUM_CLOCKS            = 2,
    parameter int PLL_RST_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES    = 50000,
    parameter int RELOCK_TIMEOUT_CYCLES = 500000,
    parameter int STAGGER_CYCLES        = 8,
    parameter int CNT_W                 = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_supervisor_if.slave sup
);
    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B   = (RELOCK_TIMEOUT_CYCLES > STAGGER_CYCLES) ? RELOCK_TIMEOUT_CYCLES : STAGGER_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int SW      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_LAST    = SW'(NUM_CLOCKS - 1);

    logic                  sync_meta_reg, lock_s_reg;
    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [SW-1:0]         slot_reg, slot_next;
    logic                  pll_rst_reg, pll_rst_next;
    logic [NUM_CLOCKS-1:0] domain_rst_reg, domain_rst_next;
    logic                  ready_reg, ready_next;
    logic [CNT_W-1:0]      count_reg, count_next;

    logic          lock_loss, kill, count_inc;
    logic          stable_done, stagger_done, rel_fire;
    logic [SW-1:0] rel_slot;

    assign lock_loss    = ((state_reg == S_RELEASE) || (state_reg == S_RUN)) && !lock_s_reg;
    assign kill         = sup.force_relock || lock_loss;
    assign count_inc    = lock_loss && !sup.force_relock;
    assign stable_done  = (state_reg == S_STABLE) && lock_s_reg && (cnt_reg == STABLE_LAST);
    assign stagger_done = (state_reg == S_RELEASE) && (cnt_reg == STAGGER_LAST);
    // Slot 0 is released on the STABLE->RELEASE edge itself.
    assign rel_fire     = (stable_done || stagger_done) && !kill;
    assign rel_slot     = (state_reg == S_STABLE) ? '0 : slot_reg;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_meta_reg  <= 1'b0;
            lock_s_reg     <= 1'b0;
            state_reg      <= S_RESET_PLL;
            cnt_reg        <= '0;
            slot_reg       <= '0;
            pll_rst_reg    <= 1'b1;
            domain_rst_reg <= '1;
            ready_reg      <= 1'b0;
            count_reg      <= '0;
        end else begin
            sync_meta_reg  <= sup.pll_locked;
            lock_s_reg     <= sync_meta_reg;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            slot_reg       <= slot_next;
            pll_rst_reg    <= pll_rst_next;
            domain_rst_reg <= domain_rst_next;
            ready_reg      <= ready_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        slot_next  = slot_reg;
        case (state_reg)
            S_RESET_PLL: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_reg) begin
                    state_next = S_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = S_RESET_PLL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s_reg) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = (NUM_CLOCKS == 1) ? S_RUN : S_RELEASE;
                    cnt_next   = '0;
                    slot_next  = SW'(1);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_reg == STAGGER_LAST) begin
                    cnt_next  = '0;
                    slot_next = slot_reg + 1'b1;
                    if (slot_reg == SLOT_LAST) state_next = S_RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RUN: cnt_next = '0;
            default: begin
                state_next = S_RESET_PLL;
                cnt_next   = '0;
            end
        endcase
        if (kill) begin
            state_next = S_RESET_PLL;
            cnt_next   = '0;
        end
    end

    always_comb begin
        pll_rst_next = (state_next == S_RESET_PLL);
        ready_next   = (state_next == S_RUN);
        count_next   = count_reg;
        // A clear coinciding with a new loss still records that loss.
        if (sup.clear_count)
            count_next = count_inc ? CNT_W'(1) : '0;
        else if (count_inc && !(&count_reg))
            count_next = count_reg + 1'b1;
    end

    for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_dom
        assign domain_rst_next[gi] =
            kill                                 ? 1'b1 :
            (state_reg == S_RUN)                 ? ~sup.chan_en[gi] :
            (rel_fire && (rel_slot == SW'(gi)))  ? ~sup.chan_en[gi] :
                                                   domain_rst_reg[gi];
    end

    assign sup.pll_rst         = pll_rst_reg;
    assign sup.domain_rst      = domain_rst_reg;
    assign sup.ready           = ready_reg;
    assign sup.lock_loss_count = count_reg;
    assign sup.state           = state_reg;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a power-up vector table followed by
// hand-written sequences for glitch, timeout, lock loss, channel enables and collisions.
module tb_pll_lock_supervisor;
    logic refclk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor_if #(.NUM_CLOCKS(3), .CNT_W(2)) bus ();

    pll_lock_supervisor #(
        .NUM_CLOCKS(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
        .RELOCK_TIMEOUT_CYCLES(32), .STAGGER_CYCLES(2), .CNT_W(2)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .sup   (bus.slave)
    );

    typedef struct {
        int         rep;
        logic       locked;
        logic       frc;
        logic [2:0] chan;
        logic       clr;
        logic       rst_i;
        logic       e_pll;
        logic [2:0] e_dom;
        logic       e_rdy;
        logic [1:0] e_cnt;
        logic [2:0] e_st;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check_all(input string name, input logic e_pll, input logic [2:0] e_dom,
                             input logic e_rdy, input logic [1:0] e_cnt, input logic [2:0] e_st);
        total++;
        if ({bus.pll_rst, bus.domain_rst, bus.ready, bus.lock_loss_count, bus.state} !==
            {e_pll, e_dom, e_rdy, e_cnt, e_st}) begin
            bad++;
            $display("FAIL %s: got pll_rst=%b dom=%b ready=%b cnt=%0d state=%0d, want pll_rst=%b dom=%b ready=%b cnt=%0d state=%0d",
                     name, bus.pll_rst, bus.domain_rst, bus.ready, bus.lock_loss_count, bus.state,
                     e_pll, e_dom, e_rdy, e_cnt, e_st);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.state != s && n < budget);
        chk(name, int'(bus.state), int'(s));
    endtask

    initial begin
        // rep, locked, force, chan, clr, rst | pll_rst, dom, ready, cnt, state
        tbl[0] = '{2, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 2'd0, 3'd0}; // reset
        tbl[1] = '{3, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 2'd0, 3'd0}; // E0..E2
        tbl[2] = '{7, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 3'd1}; // E3..E9
        tbl[3] = '{2, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 3'd1}; // E10,E11 sync
        tbl[4] = '{8, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 3'd2}; // E12..E19
        tbl[5] = '{2, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 2'd0, 3'd3}; // E20,E21
        tbl[6] = '{2, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 2'd0, 3'd3}; // E22,E23
        tbl[7] = '{3, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 3'd4}; // E24..E26
        tbl[8] = '{2, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 3'd4}; // loss in sync
        tbl[9] = '{1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 2'd1, 3'd0}; // loss acted on

        rst              = 1'b1;
        bus.pll_locked   = 1'b0;
        bus.force_relock = 1'b0;
        bus.chan_en      = 3'b111;
        bus.clear_count  = 1'b0;

        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                rst              = tbl[i].rst_i;
                bus.pll_locked   = tbl[i].locked;
                bus.force_relock = tbl[i].frc;
                bus.chan_en      = tbl[i].chan;
                bus.clear_count  = tbl[i].clr;
                tick();
                check_all($sformatf("vec%0d_%0d", i, r), tbl[i].e_pll, tbl[i].e_dom,
                          tbl[i].e_rdy, tbl[i].e_cnt, tbl[i].e_st);
            end
            $display("row %0d: %0d cycles applied", i, tbl[i].rep);
        end

        // Repeated lock loss in RUN; count saturates at 3.
        for (int k = 2; k <= 4; k++) begin
            bus.pll_locked = 1'b1;
            wait_state($sformatf("loss%0d_run", k), 3'd4, 100);
            bus.pll_locked = 1'b0;
            tick();
            chk($sformatf("loss%0d_hold_a", k), int'(bus.domain_rst), 0);
            tick();
            chk($sformatf("loss%0d_hold_b", k), int'(bus.domain_rst), 0);
            tick();
            check_all($sformatf("loss%0d", k), 1'b1, 3'b111, 1'b0, 2'((k > 3) ? 3 : k), 3'd0);
        end

        bus.clear_count = 1'b1;
        tick();
        bus.clear_count = 1'b0;
        chk("clear_alone", int'(bus.lock_loss_count), 0);

        // Timeout with lock held low: 4 cycles of pll_rst per 36-cycle period.
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        for (int j = 0; j < 76; j++) begin
            if (j > 0) tick();
            check_all($sformatf("timeout_j%0d", j), ((j % 36) < 4), 3'b111, 1'b0, 2'd0,
                      ((j % 36) < 4) ? 3'd0 : 3'd1);
        end

        // One-cycle glitch while in STABLE.
        bus.pll_locked = 1'b1;
        wait_state("glitch_reach_stable", 3'd2, 100);
        tick();
        tick();
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        chk("glitch_a", int'(bus.state), 2);
        tick();
        chk("glitch_b", int'(bus.state), 2);
        tick();
        check_all("glitch_wait", 1'b0, 3'b111, 1'b0, 2'd0, 3'd1);
        tick();
        check_all("glitch_restable", 1'b0, 3'b111, 1'b0, 2'd0, 3'd2);
        for (int j = 0; j < 7; j++) tick();
        check_all("glitch_still_stable", 1'b0, 3'b111, 1'b0, 2'd0, 3'd2);
        tick();
        check_all("glitch_release", 1'b0, 3'b110, 1'b0, 2'd0, 3'd3);

        // Channel 1 disabled keeps its slot; enabling it in RUN releases it next edge.
        bus.force_relock = 1'b1;
        bus.chan_en      = 3'b101;
        tick();
        bus.force_relock = 1'b0;
        wait_state("chan_reach_release", 3'd3, 100);
        check_all("chan_slot0", 1'b0, 3'b110, 1'b0, 2'd0, 3'd3);
        tick();
        tick();
        check_all("chan_slot1_skipped", 1'b0, 3'b110, 1'b0, 2'd0, 3'd3);
        tick();
        tick();
        check_all("chan_slot2", 1'b0, 3'b010, 1'b1, 2'd0, 3'd4);
        bus.chan_en = 3'b111;
        tick();
        check_all("chan_enable_run", 1'b0, 3'b000, 1'b1, 2'd0, 3'd4);

        // force_relock during RELEASE.
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        wait_state("force_reach_release", 3'd3, 100);
        tick();
        bus.force_relock = 1'b1;
        tick();
        bus.force_relock = 1'b0;
        check_all("force_in_release", 1'b1, 3'b111, 1'b0, 2'd0, 3'd0);

        // Plain loss to make the count nonzero, then a loss with clear on the same edge.
        wait_state("plain_reach_run", 3'd4, 100);
        bus.pll_locked = 1'b0;
        tick();
        tick();
        tick();
        check_all("plain_loss", 1'b1, 3'b111, 1'b0, 2'd1, 3'd0);
        bus.pll_locked = 1'b1;
        wait_state("clr_reach_run", 3'd4, 100);
        bus.pll_locked = 1'b0;
        tick();
        tick();
        bus.clear_count = 1'b1;
        tick();
        bus.clear_count = 1'b0;
        check_all("clear_with_loss", 1'b1, 3'b111, 1'b0, 2'd1, 3'd0);

        // rst mid-RUN.
        bus.pll_locked = 1'b1;
        wait_state("rst_reach_run", 3'd4, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("rst_in_run", 1'b1, 3'b111, 1'b0, 2'd0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
